// File: rtl/instr_ram_loader_pkg.sv
// Shared types and default sizes for the instruction RAM loader.
// Imported by the loader top and its code RAM.
package instr_ram_loader_pkg;

    localparam int D_DEF = 12;
    localparam int W_DEF = 9;
    localparam int B_DEF = 5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_BT,
        LOAD_LEN,
        LOAD_CODE,
        RUN
    } state_t;

endpackage

// File: rtl/instr_ram_loader_if.sv
// Load handshake, fetch and branch-table signals of the loader.
// master drives load/fetch requests, slave is the loader itself.
interface instr_ram_loader_if #(
    parameter int D = instr_ram_loader_pkg::D_DEF,
    parameter int W = instr_ram_loader_pkg::W_DEF,
    parameter int B = instr_ram_loader_pkg::B_DEF
) ();

    logic         load_start;
    logic         load_valid;
    logic [D-1:0] load_data;
    logic         load_ready;
    logic         loaded;
    logic [D-1:0] prog_ctr;
    logic [W-1:0] mach_code;
    logic         fetch_valid;
    logic [B-1:0] bt_idx;
    logic [D-1:0] bt_target;

    modport master (
        output load_start, load_valid, load_data,
        output prog_ctr, bt_idx,
        input  load_ready, loaded,
        input  mach_code, fetch_valid, bt_target
    );

    modport slave (
        input  load_start, load_valid, load_data,
        input  prog_ctr, bt_idx,
        output load_ready, loaded,
        output mach_code, fetch_valid, bt_target
    );

endinterface

// File: rtl/instr_ram_loader_code_ram.sv
// Code store: one write port, one registered read port.
// Contents are never cleared; the loader masks stale data.
module code_ram #(
    parameter int D = instr_ram_loader_pkg::D_DEF,
    parameter int W = instr_ram_loader_pkg::W_DEF
) (
    input  logic         clk,
    input  logic         we,
    input  logic [D-1:0] waddr,
    input  logic [W-1:0] wdata,
    input  logic [D-1:0] raddr,
    output logic [W-1:0] rdata
);

    logic [W-1:0] mem [2**D];

    // Write when loading, read every cycle with one cycle of latency.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/instr_ram_loader.sv
// Streams a branch table, a length word and a code image in,
// then serves registered instruction fetch and branch lookups.
module instr_ram_loader
    import instr_ram_loader_pkg::*;
#(
    parameter int D = D_DEF,
    parameter int W = W_DEF,
    parameter int B = B_DEF
) (
    input logic              clk,
    input logic              reset,
    instr_ram_loader_if.slave bus
);

    localparam int NBT = 2**B;
    localparam logic [D:0] FULL = {1'b1, {D{1'b0}}};
    localparam logic [D:0] BT_LAST = (D+1)'(NBT - 1);

    state_t       state;
    state_t       state_nx;
    logic [D:0]   cnt;
    logic [D:0]   cnt_nx;
    logic [D:0]   cnt_inc;
    logic [D:0]   n_len;
    logic [D:0]   len_nx;
    logic         xfer;
    logic         run_live;
    logic         loaded;
    logic         fetch_valid;
    logic         in_range;
    logic [D-1:0] bt_target;
    logic [W-1:0] rdata;
    logic         code_we;
    logic [D-1:0] bt [NBT];

    // A restart pulse suppresses any word offered alongside it.
    assign xfer = bus.load_valid && bus.load_ready && !bus.load_start;
    assign cnt_inc = cnt + 1'b1;
    assign run_live = (state == RUN) && !bus.load_start;
    assign code_we = xfer && (state == LOAD_CODE);

    assign bus.load_ready = (state == LOAD_BT) ||
                            (state == LOAD_LEN) ||
                            (state == LOAD_CODE);
    assign bus.loaded = loaded;
    assign bus.fetch_valid = fetch_valid;
    assign bus.bt_target = bt_target;
    assign bus.mach_code = in_range ? rdata : '0;

    // Next state, word counter and code length.
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        len_nx = n_len;
        if (bus.load_start) begin
            state_nx = LOAD_BT;
            cnt_nx = '0;
        end else if (xfer) begin
            case (state)
                LOAD_BT: begin
                    if (cnt == BT_LAST) begin
                        state_nx = LOAD_LEN;
                        cnt_nx = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                LOAD_LEN: begin
                    len_nx = (bus.load_data == '0) ? FULL
                                                   : {1'b0, bus.load_data};
                    cnt_nx = '0;
                    state_nx = LOAD_CODE;
                end
                LOAD_CODE: begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc == n_len)
                        state_nx = RUN;
                end
                default: ;
            endcase
        end
    end

    // Control state; loaded follows RUN entry and drops on restart.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            n_len <= '0;
            loaded <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            n_len <= len_nx;
            loaded <= (state_nx == RUN);
        end
    end

    // Branch table fills from the top entry downwards.
    always_ff @(posedge clk) begin
        if (xfer && (state == LOAD_BT))
            bt[~cnt[B-1:0]] <= bus.load_data;
    end

    // Fetch and lookup qualifiers; everything reads zero outside RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_valid <= 1'b0;
            in_range <= 1'b0;
            bt_target <= '0;
        end else begin
            fetch_valid <= run_live;
            in_range <= run_live && ({1'b0, bus.prog_ctr} < n_len);
            bt_target <= run_live ? bt[bus.bt_idx] : '0;
        end
    end

    code_ram #(
        .D(D),
        .W(W)
    ) u_code_ram (
        .clk  (clk),
        .we   (code_we),
        .waddr(cnt[D-1:0]),
        .wdata(bus.load_data[W-1:0]),
        .raddr(bus.prog_ctr),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_instr_ram_loader.sv
// Directed and randomized bench for instr_ram_loader.
// Default-size instance plus a D=4 instance for the full-depth case.
module tb_instr_ram_loader;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    instr_ram_loader_if #(.D(12), .W(9), .B(5)) a ();
    instr_ram_loader_if #(.D(4), .W(4), .B(2)) b ();

    instr_ram_loader #(.D(12), .W(9), .B(5)) dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (a.slave)
    );

    instr_ram_loader #(.D(4), .W(4), .B(2)) dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (b.slave)
    );

    int checks = 0;
    int errors = 0;
    int ready_low = 0;

    logic [11:0] bt_m [32];
    logic [8:0]  code_m [4096];
    int          n_m = 0;
    logic [11:0] img_bt [32];
    logic [11:0] img_code [$];
    logic [3:0]  b_bt [4];
    logic [3:0]  b_code [16];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [11:0] d, input bit gap);
        if (gap) begin
            a.load_valid = 1'b0;
            a.load_data = 12'($urandom);
            tick();
        end
        a.load_valid = 1'b1;
        a.load_data = d;
        @(negedge clk);
        if (a.load_ready !== 1'b1)
            ready_low++;
        tick();
        a.load_valid = 1'b0;
    endtask

    task automatic start_a();
        a.load_start = 1'b1;
        a.load_valid = 1'b1;
        a.load_data = 12'($urandom);
        tick();
        a.load_start = 1'b0;
        a.load_valid = 1'b0;
    endtask

    task automatic rand_img(input int n);
        for (int i = 0; i < 32; i++)
            img_bt[i] = 12'($urandom);
        img_code.delete();
        for (int k = 0; k < n; k++)
            img_code.push_back(12'($urandom));
    endtask

    task automatic load_a(input bit gap);
        start_a();
        for (int i = 0; i < 32; i++)
            push_a(img_bt[i], gap);
        push_a(12'(img_code.size()), gap);
        foreach (img_code[k])
            push_a(img_code[k], gap);
        for (int i = 0; i < 32; i++)
            bt_m[31 - i] = img_bt[i];
        foreach (img_code[k])
            code_m[k] = img_code[k][8:0];
        n_m = img_code.size();
    endtask

    task automatic wait_loaded_a(input string tag);
        for (int i = 0; i < 4 && a.loaded !== 1'b1; i++)
            @(negedge clk);
        check(tag, a.loaded, 1);
    endtask

    task automatic fetch_a(input string tag, input logic [11:0] pc);
        logic [8:0] exp;
        a.prog_ctr = pc;
        tick();
        @(negedge clk);
        exp = (int'(pc) < n_m) ? code_m[pc] : 9'h000;
        check({tag, "_code"}, a.mach_code, exp);
        check({tag, "_fv"}, a.fetch_valid, 1);
    endtask

    task automatic bt_a(input string tag, input logic [4:0] idx);
        a.bt_idx = idx;
        tick();
        @(negedge clk);
        check(tag, a.bt_target, bt_m[idx]);
    endtask

    task automatic push_b(input logic [3:0] d);
        b.load_valid = 1'b1;
        b.load_data = d;
        tick();
        b.load_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        a.load_start = 1'b0;
        a.load_valid = 1'b0;
        a.load_data = '0;
        a.prog_ctr = '0;
        a.bt_idx = '0;
        b.load_start = 1'b0;
        b.load_valid = 1'b0;
        b.load_data = '0;
        b.prog_ctr = '0;
        b.bt_idx = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_loaded", a.loaded, 0);
        check("rst_ready", a.load_ready, 0);
        check("rst_fv", a.fetch_valid, 0);
        check("rst_code", a.mach_code, 0);
        check("rst_bt", a.bt_target, 0);
        check("rst_b_loaded", b.loaded, 0);
        reset = 1'b0;
        a.prog_ctr = 12'd3;
        a.load_valid = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("idle_ready", a.load_ready, 0);
        check("idle_fv", a.fetch_valid, 0);
        a.load_valid = 1'b0;

        // Directed image: branch words 0..31, four code words.
        for (int i = 0; i < 32; i++)
            img_bt[i] = 12'(i);
        img_code = '{12'h07E, 12'h066, 12'h07A, 12'h1DE};
        load_a(1'b0);
        wait_loaded_a("d_loaded");
        bt_a("d_bt31", 5'd31);
        bt_a("d_bt0", 5'd0);
        check("d_bt0_const", a.bt_target, 12'd31);
        fetch_a("d_pc3", 12'd3);
        check("d_pc3_const", a.mach_code, 9'h1DE);
        fetch_a("d_pc0", 12'd0);
        fetch_a("d_pc4", 12'd4);
        fetch_a("d_pc4095", 12'd4095);

        // Same image with load_valid toggling each cycle.
        img_code = '{12'hE7E, 12'h866, 12'h47A, 12'h1DE};
        ready_low = 0;
        load_a(1'b1);
        wait_loaded_a("g_loaded");
        check("g_ready_low", ready_low, 0);
        bt_a("g_bt31", 5'd31);
        bt_a("g_bt0", 5'd0);
        fetch_a("g_pc3", 12'd3);
        fetch_a("g_pc0", 12'd0);

        // Abort mid-code, then a short image hides the partial words.
        rand_img(20);
        start_a();
        @(negedge clk);
        check("ab_loaded", a.loaded, 0);
        check("ab_fv", a.fetch_valid, 0);
        check("ab_code", a.mach_code, 0);
        check("ab_bt", a.bt_target, 0);
        for (int i = 0; i < 32; i++)
            push_a(img_bt[i], 1'b0);
        push_a(12'd20, 1'b0);
        for (int k = 0; k < 10; k++)
            push_a(img_code[k] | 12'h001, 1'b0);
        @(negedge clk);
        check("ab_mid_loaded", a.loaded, 0);
        rand_img(2);
        load_a(1'b0);
        wait_loaded_a("ab_loaded2");
        fetch_a("ab_pc5", 12'd5);
        fetch_a("ab_pc1", 12'd1);

        // Restart coinciding with the final code word wins.
        rand_img(3);
        start_a();
        for (int i = 0; i < 32; i++)
            push_a(img_bt[i], 1'b0);
        push_a(12'd3, 1'b0);
        push_a(img_code[0], 1'b0);
        push_a(img_code[1], 1'b0);
        a.load_valid = 1'b1;
        a.load_data = img_code[2];
        a.load_start = 1'b1;
        tick();
        a.load_start = 1'b0;
        a.load_valid = 1'b0;
        @(negedge clk);
        check("race_loaded", a.loaded, 0);
        check("race_ready", a.load_ready, 1);
        repeat (3) tick();
        @(negedge clk);
        check("race_loaded_late", a.loaded, 0);

        // Randomized images and lookups.
        for (int r = 0; r < 3; r++) begin
            rand_img(int'($urandom_range(1, 40)));
            load_a(1'($urandom));
            wait_loaded_a("r_loaded");
            for (int j = 0; j < 4; j++)
                bt_a("r_bt", 5'($urandom));
            for (int j = 0; j < 5; j++)
                fetch_a("r_pc", 12'($urandom_range(0, n_m + 4)));
        end

        // Reset in the middle of the code phase.
        rand_img(8);
        start_a();
        for (int i = 0; i < 32; i++)
            push_a(img_bt[i], 1'b0);
        push_a(12'd8, 1'b0);
        for (int k = 0; k < 3; k++)
            push_a(img_code[k], 1'b0);
        reset = 1'b1;
        a.load_valid = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mr_loaded", a.loaded, 0);
        check("mr_ready", a.load_ready, 0);
        check("mr_fv", a.fetch_valid, 0);
        repeat (2) tick();
        @(negedge clk);
        check("mr_idle_ready", a.load_ready, 0);
        check("mr_idle_fv", a.fetch_valid, 0);
        a.load_valid = 1'b0;
        rand_img(6);
        load_a(1'b0);
        wait_loaded_a("mr_reload");
        fetch_a("mr_pc5", 12'd5);

        // Small instance: length word 0 means all 16 locations.
        for (int i = 0; i < 4; i++)
            b_bt[i] = 4'($urandom);
        for (int k = 0; k < 16; k++)
            b_code[k] = 4'($urandom);
        b.load_start = 1'b1;
        tick();
        b.load_start = 1'b0;
        for (int i = 0; i < 4; i++)
            push_b(b_bt[i]);
        push_b(4'd0);
        for (int k = 0; k < 15; k++)
            push_b(b_code[k]);
        @(negedge clk);
        check("b_loaded_15", b.loaded, 0);
        push_b(b_code[15]);
        @(negedge clk);
        check("b_loaded_16", b.loaded, 1);
        b.prog_ctr = 4'd15;
        b.bt_idx = 2'd0;
        tick();
        @(negedge clk);
        check("b_pc15", b.mach_code, b_code[15]);
        check("b_fv", b.fetch_valid, 1);
        check("b_bt0", b.bt_target, b_bt[3]);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_ram_loader.md
INSTR_RAM_LOADER -- requirements
Module: instr_ram_loader

Interface
REQ-001 SHALL have parameter D, default 12, meaning program-counter and branch-target width (code depth 2**D words).
REQ-002 SHALL have parameter W, default 9, meaning machine-code width; D >= W is required.
REQ-003 SHALL have parameter B, default 5, meaning branch-table index width (2**B entries).
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port load_start, input, 1, pulse that begins a new image load.
REQ-007 SHALL have port load_valid, input, 1, load word present.
REQ-008 SHALL have port load_data, input, D, load word.
REQ-009 SHALL have port load_ready, output, 1, loader accepts the word this cycle.
REQ-010 SHALL have port loaded, output, 1, a complete image is resident and fetch is live.
REQ-011 SHALL have port prog_ctr, input, D, fetch address.
REQ-012 SHALL have port mach_code, output, W, fetched instruction.
REQ-013 SHALL have port fetch_valid, output, 1, mach_code is valid.
REQ-014 SHALL have port bt_idx, input, B, branch-table index.
REQ-015 SHALL have port bt_target, output, D, branch-table entry.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD_BT, LOAD_LEN, LOAD_CODE, RUN.
REQ-017 A word SHALL transfer only when load_valid and load_ready are both high; load_ready SHALL be high exactly in LOAD_BT, LOAD_LEN, LOAD_CODE.
REQ-018 A load_start in any state except reset SHALL move to LOAD_BT next cycle, clear loaded, and zero the word counter; any word offered in that same cycle SHALL be dropped.
REQ-019 LOAD_BT SHALL accept 2**B words; the k-th accepted word (k from 0) SHALL write branch entry 2**B-1-k (reverse order).
REQ-020 After the last branch word, LOAD_LEN SHALL accept one word N, the code length; N = 0 SHALL mean 2**D.
REQ-021 LOAD_CODE SHALL accept N words; the k-th SHALL write load_data[W-1:0] to code address k; upper D-W bits SHALL be ignored.
REQ-022 After the N-th code word the FSM SHALL enter RUN and assert loaded the following cycle.
REQ-023 mach_code and fetch_valid SHALL be registered: one-cycle latency from prog_ctr.
REQ-024 In RUN, fetch_valid SHALL be 1 the cycle after any prog_ctr sample; mach_code SHALL be code[prog_ctr] if prog_ctr < N, else all zeros (stale-image protection).
REQ-025 Outside RUN, fetch_valid SHALL be 0 and mach_code all zeros.
REQ-026 bt_target SHALL be registered, one-cycle latency from bt_idx, valid only while loaded; outside RUN it SHALL read zero.
REQ-027 The word counter SHALL be D+1 bits so N = 2**D terminates without wrap.
REQ-028 A load_start in the same cycle as the final code word SHALL win: no RUN entry, restart in LOAD_BT.

Reset
REQ-029 On reset, state SHALL be IDLE; loaded, load_ready, fetch_valid SHALL be 0; mach_code and bt_target SHALL be zero; N and counter SHALL be zero.
REQ-030 Reset SHALL take precedence over load_start and any transfer; memory contents need not be cleared, since REQ-024/025/026 mask them.
REQ-031 Reset mid-load SHALL abandon the partial image; a full reload SHALL be required.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and default values of D, W, B.
REQ-033 Code storage SHALL be one sub-module, code_ram: single write port, one registered read port, parametrised by D and W.
REQ-034 The branch table SHALL be a 2**B x D register array inside instr_ram_loader.

Verification
REQ-035 Reset, load_start, 32 branch words 0..31, N=4, code 9'h07E,9'h066,9'h07A,9'h1DE -> loaded high; bt_idx=31 gives 0, bt_idx=0 gives 31; prog_ctr=3 gives 9'h1DE one cycle later.
REQ-036 After REQ-035 image, prog_ctr=4 and prog_ctr=4095 -> mach_code 0, fetch_valid 1.
REQ-037 load_valid toggled every other cycle throughout load -> same results as REQ-035; load_ready never low in load states.
REQ-038 load_start asserted after 10 code words of N=20, then full image with N=2 -> loaded high; prog_ctr=5 reads 0.
REQ-039 reset asserted during LOAD_CODE -> next cycle state IDLE, loaded 0, load_ready 0, fetch_valid 0.
REQ-040 D=4, N=0 (16 words) -> loaded after exactly 16 code words; prog_ctr=15 returns last word.
